sumador_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one 4-bit add/subtract unit (sumayresta) between two requesters.

---
 rtl/sumador_arbiter_if.sv | 51 +++++
 rtl/sumador_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sumador_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sumador_arbiter_if
// Brief    : Requester, result and shared add/sub unit signals of sumador_arbiter.
//            op_count exists only when OP_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface sumador_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             sel0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sel1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic [1:0]       gnt;
    logic             busy;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sel;
    logic [WIDTH-1:0] S_in;
    logic             Co_in;
`ifdef OP_COUNT_EN
    logic [7:0]       op_count;
`endif

    // Requesters plus the shared unit drive the arbiter.
    modport master (
        output req0, a0, b0, sel0, req1, a1, b1, sel1, S_in, Co_in,
        input  ack0, ack1, res, cout, gnt, busy, A, B, Sel
`ifdef OP_COUNT_EN
        , input op_count
`endif
    );

    modport slave (
        input  req0, a0, b0, sel0, req1, a1, b1, sel1, S_in, Co_in,
        output ack0, ack1, res, cout, gnt, busy, A, B, Sel
`ifdef OP_COUNT_EN
        , output op_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sumador_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sumador_arbiter
// Brief    : Round-robin sharing of one add/subtract unit between two requesters.
//            Define OP_COUNT_EN to add the 8-bit completed-operation counter.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input wire               clk2,
    input wire               rst,
    sumador_arbiter_if.slave bus
);
    localparam int c_cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic               r_last, w_last;
    logic [1:0]         r_gnt, w_gnt;
    logic [WIDTH-1:0]   r_a, w_a, r_b, w_b, r_res, w_res;
    logic               r_sel, w_sel, r_cout, w_cout;
    logic               w_ack0, w_ack1, w_busy;
    logic               w_pick1;
`ifdef OP_COUNT_EN
    logic [7:0]         r_op_count, w_op_count;
`endif

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    assign w_pick1 = bus.req1 && (!bus.req0 || !r_last);

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_last  = r_last;
        w_gnt   = r_gnt;
        w_a     = r_a;
        w_b     = r_b;
        w_sel   = r_sel;
        w_res   = r_res;
        w_cout  = r_cout;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_busy  = 1'b0;
`ifdef OP_COUNT_EN
        w_op_count = r_op_count;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_state = S_EXEC;
                    w_cnt   = c_cnt_load;
                    w_gnt   = w_pick1 ? 2'b10 : 2'b01;
                    w_a     = w_pick1 ? bus.a1 : bus.a0;
                    w_b     = w_pick1 ? bus.b1 : bus.b0;
                    w_sel   = w_pick1 ? bus.sel1 : bus.sel0;
                end
            end
            S_EXEC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_res   = bus.S_in;
                    w_cout  = bus.Co_in;
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                w_busy  = 1'b1;
                w_ack0  = r_gnt[0];
                w_ack1  = r_gnt[1];
                w_last  = r_gnt[1];
                w_gnt   = 2'b00;
                w_state = S_IDLE;
`ifdef OP_COUNT_EN
                w_op_count = r_op_count + 8'd1;
`endif
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_last <= 1'b1;
            r_gnt  <= 2'b00;
            r_a    <= '0;
            r_b    <= '0;
            r_sel  <= 1'b0;
            r_res  <= '0;
            r_cout <= 1'b0;
`ifdef OP_COUNT_EN
            r_op_count <= 8'd0;
`endif
        end else begin
            r_cnt  <= w_cnt;
            r_last <= w_last;
            r_gnt  <= w_gnt;
            r_a    <= w_a;
            r_b    <= w_b;
            r_sel  <= w_sel;
            r_res  <= w_res;
            r_cout <= w_cout;
`ifdef OP_COUNT_EN
            r_op_count <= w_op_count;
`endif
        end
    end

    assign bus.ack0 = w_ack0;
    assign bus.ack1 = w_ack1;
    assign bus.busy = w_busy;
    assign bus.gnt  = r_gnt;
    assign bus.A    = r_a;
    assign bus.B    = r_b;
    assign bus.Sel  = r_sel;
    assign bus.res  = r_res;
    assign bus.cout = r_cout;
`ifdef OP_COUNT_EN
    assign bus.op_count = r_op_count;
`endif
endmodule
`default_nettype wire
